// File: rtl/neuron_driver.sv
`default_nettype none
// ============================================================================
// Module   : neuron_driver
// Brief    : Initiator-side front end for a single neuron. Operands arrive one
//            per cycle on a valid/ready stream. They are assembled into the
//            neuron's parallel operand array and held stable while the neuron
//            computes. The neuron's output is then captured and presented on
//            a valid/ready result port.
// Ports    : clock        - rising-edge clock
//            reset        - synchronous, active-low
//            in_valid     - operand stream valid
//            in_ready     - driver can accept an operand (LOAD state only)
//            in_data      - operand; array index = arrival order
//            inputs       - registered operand array to the neuron
//            inputs_ready - operands complete and stable (to neuron)
//            output_ready - neuron result valid (from neuron)
//            out          - neuron result
//            result_valid - result holds a captured neuron output
//            result_ready - downstream accepts result
//            result       - captured neuron output
// Revision : 1.0 - initial release
// ============================================================================
module neuron_driver #(
    parameter  int NUM_INPUTS     = 120,
    // Fixed-point format shared with the neuron; not user-configurable.
    localparam int INTEGER_WIDTH  = 16,
    localparam int FRACTION_WIDTH = 16
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] in_data,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] inputs [NUM_INPUTS],
    output logic                                       inputs_ready,
    input  logic                                       output_ready,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] out,
    output logic                                       result_valid,
    input  logic                                       result_ready,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] result
);

    localparam int c_cnt_w = $clog2(NUM_INPUTS);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(NUM_INPUTS - 1);

    localparam logic [1:0] c_st_load    = 2'd0;
    localparam logic [1:0] c_st_compute = 2'd1;
    localparam logic [1:0] c_st_result  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic               w_in_fire;
    logic               w_last;

    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] r_inputs [NUM_INPUTS];
    logic                                          r_inputs_ready;
    logic                                          r_result_valid;
    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] r_result;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_in_fire    = in_valid && (r_state == c_st_load);
        w_last       = (r_count == c_last_idx);
        w_state_next = r_state;
        case (r_state)
            c_st_load:    if (w_in_fire && w_last) w_state_next = c_st_compute;
            c_st_compute: if (output_ready)        w_state_next = c_st_result;
            // result_valid is always high in RESULT, so ready alone completes the transfer.
            c_st_result:  if (result_ready)        w_state_next = c_st_load;
            default:                               w_state_next = c_st_load;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= c_st_load;
            r_count        <= '0;
            r_inputs_ready <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_inputs[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_st_load: begin
                    if (w_in_fire) begin
                        r_inputs[r_count] <= in_data;
                        r_count           <= r_count + c_cnt_w'(1);
                        if (w_last) begin
                            r_inputs_ready <= 1'b1;
                        end
                    end
                end
                c_st_compute: begin
                    if (output_ready) begin
                        r_result       <= out;
                        r_result_valid <= 1'b1;
                        r_inputs_ready <= 1'b0;
                    end
                end
                c_st_result: begin
                    // Operand array is deliberately left intact; the next load overwrites it.
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_count        <= '0;
                    end
                end
                default: begin
                    r_count        <= '0;
                    r_inputs_ready <= 1'b0;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: in_ready decoded from state, everything else registered
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = (r_state == c_st_load);
        inputs_ready = r_inputs_ready;
        result_valid = r_result_valid;
        result       = r_result;
        inputs       = r_inputs;
    end

endmodule
`default_nettype wire
